// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp indices and the wrap-around request search
// used by the traffic light controller.
package traffic_pkg;

    // Phase encodings, as seen on phase_o
    localparam logic [2:0] PH_ALL_RED = 3'd0;
    localparam logic [2:0] PH_GREEN   = 3'd1;
    localparam logic [2:0] PH_YELLOW  = 3'd2;
    localparam logic [2:0] PH_FLASH   = 3'd3;

    // Bit positions inside a per-approach {green, yellow, red} lamp vector
    localparam int LAMP_RED    = 0;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_GREEN  = 2;

    // Widest supported junction; the search works on this fixed width
    localparam int MAX_DIR = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } sel_t;

    // First set bit of pend, starting just after cur_dir and wrapping, so
    // cur_dir itself is considered last. Only the low num_dir bits matter.
    function automatic sel_t first_set_wrap(input logic [MAX_DIR-1:0] pend,
                                            input logic [2:0]         cur_dir,
                                            input int unsigned        num_dir);
        sel_t        r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 1; k <= MAX_DIR; k++) begin
            cand = ({29'd0, cur_dir} + k) % num_dir;
            if (k <= num_dir && !r.found && pend[cand[2:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_rr_next_sel.sv
// Combinational choice of the next approach to serve: strict rotation, or
// the next approach holding a pending request when skipping is enabled.
module rr_next_sel
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int SKIP_EMPTY = 0,
    parameter int DIR_W      = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] pend_i,
    input  logic [DIR_W-1:0]   dir_i,
    output logic [DIR_W-1:0]   next_dir_o,
    output logic               found_o
);

    logic [MAX_DIR-1:0] pend_wide;
    logic [2:0]         dir_wide;
    sel_t               sel;

    // Widen inputs to the package search width and pick the next approach
    always_comb begin
        pend_wide                = '0;
        pend_wide[NUM_DIR-1:0]   = pend_i;
        dir_wide                 = '0;
        dir_wide[DIR_W-1:0]      = dir_i;
        sel                      = '0;
        if (SKIP_EMPTY != 0) begin
            sel = first_set_wrap(pend_wide, dir_wide, NUM_DIR);
        end else begin
            sel.found = 1'b1;
            sel.idx   = (dir_wide == 3'(NUM_DIR - 1)) ? 3'd0 : dir_wide + 3'd1;
        end
    end

    assign next_dir_o = DIR_W'(sel.idx);
    assign found_o    = sel.found;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller: green -> yellow -> all-red per
// approach, optional skipping of idle approaches, flashing yellow when
// disabled. All lamp outputs are registered.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int FLASH_CYC  = 4,
    parameter int CNT_W      = 8,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       en,
    input  logic [NUM_DIR-1:0]         req_i,
    output logic [NUM_DIR-1:0]         red_o,
    output logic [NUM_DIR-1:0]         yellow_o,
    output logic [NUM_DIR-1:0]         green_o,
    output logic [$clog2(NUM_DIR)-1:0] dir_o,
    output logic [2:0]                 phase_o,
    output logic [NUM_DIR-1:0]         pend_o
);

    localparam int DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_CYC - 1);
    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

    logic [2:0]         state_q,  state_d;
    logic [DIR_W-1:0]   dir_q,    dir_d;
    logic [CNT_W-1:0]   timer_q,  timer_d;
    logic [NUM_DIR-1:0] pend_q,   pend_d;
    logic               flash_q,  flash_d;
    logic [NUM_DIR-1:0] red_q,    red_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic [NUM_DIR-1:0] green_q,  green_d;
    logic [NUM_DIR-1:0] pend_clr;
    logic [DIR_W-1:0]   sel_dir;
    logic               sel_found;
    logic [2:0]         lamp_d [NUM_DIR];

    rr_next_sel #(
        .NUM_DIR    (NUM_DIR),
        .SKIP_EMPTY (SKIP_EMPTY),
        .DIR_W      (DIR_W)
    ) u_sel (
        .pend_i     (pend_q),
        .dir_i      (dir_q),
        .next_dir_o (sel_dir),
        .found_o    (sel_found)
    );

    // State, timer, direction, request latch and lamp registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= PH_ALL_RED;
            dir_q    <= DIR_W'(NUM_DIR - 1);
            timer_q  <= T_ALLRED;
            pend_q   <= '0;
            flash_q  <= 1'b1;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            flash_q  <= flash_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    // Next-state and phase timer: flash overrides, otherwise walk the phases
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        flash_d  = flash_q;
        pend_clr = '0;
        if (!en) begin
            state_d = PH_FLASH;
            if (state_q != PH_FLASH) begin
                timer_d = T_FLASH;
                flash_d = 1'b1;
            end else if (timer_q == '0) begin
                timer_d = T_FLASH;
                flash_d = ~flash_q;
            end else begin
                timer_d = timer_q - T_ONE;
            end
        end else begin
            case (state_q)
                PH_FLASH: begin
                    state_d = PH_ALL_RED;
                    timer_d = T_ALLRED;
                end
                PH_GREEN: begin
                    if (timer_q == '0) begin
                        state_d = PH_YELLOW;
                        timer_d = T_YELLOW;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                PH_YELLOW: begin
                    if (timer_q == '0) begin
                        state_d = PH_ALL_RED;
                        timer_d = T_ALLRED;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                PH_ALL_RED: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - T_ONE;
                    end else if (sel_found) begin
                        state_d           = PH_GREEN;
                        dir_d             = sel_dir;
                        timer_d           = T_GREEN;
                        pend_clr[sel_dir] = 1'b1;
                    end
                    // no pending request: rest here with the timer at zero
                end
                default: begin
                    state_d = PH_ALL_RED;
                    timer_d = T_ALLRED;
                end
            endcase
        end
    end

    // A request arriving on the green-entry edge survives the clear
    assign pend_d = (pend_q & ~pend_clr) | req_i;

    // Lamp pattern for the state being entered, one {g,y,r} triple per approach
    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            lamp_d[i] = '0;
            case (state_d)
                PH_FLASH:  lamp_d[i][LAMP_YELLOW] = flash_d;
                PH_GREEN:  begin
                    if (DIR_W'(i) == dir_d) lamp_d[i][LAMP_GREEN] = 1'b1;
                    else                    lamp_d[i][LAMP_RED]   = 1'b1;
                end
                PH_YELLOW: begin
                    if (DIR_W'(i) == dir_d) lamp_d[i][LAMP_YELLOW] = 1'b1;
                    else                    lamp_d[i][LAMP_RED]    = 1'b1;
                end
                default:   lamp_d[i][LAMP_RED] = 1'b1;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
        assign red_d[gi]    = lamp_d[gi][LAMP_RED];
        assign yellow_d[gi] = lamp_d[gi][LAMP_YELLOW];
        assign green_d[gi]  = lamp_d[gi][LAMP_GREEN];
    end

    assign red_o    = red_q;
    assign yellow_o = yellow_q;
    assign green_o  = green_q;
    assign dir_o    = dir_q;
    assign phase_o  = state_q;
    assign pend_o   = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: expected lamp/phase snapshots are queued against
// absolute cycle numbers; a negedge monitor pops and compares them.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       res0, en0, res1, en1;
    logic [3:0] req0, req1;
    logic [3:0] red0, yel0, grn0, pend0, red1, yel1, grn1, pend1;
    logic [1:0] dir0, dir1;
    logic [2:0] ph0, ph1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    localparam int R = 2;

    typedef struct {
        int          inst;
        int          cyc;
        logic [95:0] name;
        logic [2:0]  ph;
        logic [1:0]  dir;
        logic [3:0]  red;
        logic [3:0]  yel;
        logic [3:0]  grn;
        logic [3:0]  pend;
    } exp_t;

    exp_t sb[$];

    traffic_light_ctrl #(.NUM_DIR(4), .GREEN_CYC(10), .YELLOW_CYC(2), .ALLRED_CYC(1),
                         .FLASH_CYC(4), .CNT_W(8), .SKIP_EMPTY(0)) u_dut0 (
        .clk(clk), .res(res0), .en(en0), .req_i(req0), .red_o(red0), .yellow_o(yel0),
        .green_o(grn0), .dir_o(dir0), .phase_o(ph0), .pend_o(pend0));

    traffic_light_ctrl #(.NUM_DIR(4), .GREEN_CYC(10), .YELLOW_CYC(2), .ALLRED_CYC(1),
                         .FLASH_CYC(4), .CNT_W(8), .SKIP_EMPTY(1)) u_dut1 (
        .clk(clk), .res(res1), .en(en1), .req_i(req1), .red_o(red1), .yellow_o(yel1),
        .green_o(grn1), .dir_o(dir1), .phase_o(ph1), .pend_o(pend1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int inst, input int c, input logic [95:0] nm,
                                 input logic [2:0] ph, input logic [1:0] d,
                                 input logic [3:0] r, input logic [3:0] y,
                                 input logic [3:0] g, input logic [3:0] p);
        exp_t e;
        e.inst = inst; e.cyc = c; e.name = nm; e.ph = ph; e.dir = d;
        e.red = r; e.yel = y; e.grn = g; e.pend = p;
        sb.push_back(e);
    endfunction

    function automatic void exp_green(input int inst, input int c, input logic [95:0] nm,
                                      input logic [1:0] d, input logic [3:0] p);
        logic [3:0] g;
        g = 4'b0001 << d;
        push(inst, c, nm, 3'd1, d, ~g, 4'h0, g, p);
    endfunction

    function automatic void exp_yellow(input int inst, input int c, input logic [95:0] nm,
                                       input logic [1:0] d, input logic [3:0] p);
        logic [3:0] y;
        y = 4'b0001 << d;
        push(inst, c, nm, 3'd2, d, ~y, y, 4'h0, p);
    endfunction

    function automatic void exp_allred(input int inst, input int c, input logic [95:0] nm,
                                       input logic [1:0] d, input logic [3:0] p);
        push(inst, c, nm, 3'd0, d, 4'hF, 4'h0, 4'h0, p);
    endfunction

    function automatic void exp_flash(input int inst, input int c, input logic [95:0] nm,
                                      input logic [1:0] d, input logic [3:0] y,
                                      input logic [3:0] p);
        push(inst, c, nm, 3'd3, d, 4'h0, y, 4'h0, p);
    endfunction

    // Monitor: compare every queued snapshot due at this cycle
    always @(negedge clk) begin
        logic [2:0] a_ph;
        logic [1:0] a_dir;
        logic [3:0] a_red, a_yel, a_grn, a_pend;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %0s missed: due cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                if (sb[i].inst == 0) begin
                    a_ph = ph0; a_dir = dir0; a_red = red0; a_yel = yel0; a_grn = grn0; a_pend = pend0;
                end else begin
                    a_ph = ph1; a_dir = dir1; a_red = red1; a_yel = yel1; a_grn = grn1; a_pend = pend1;
                end
                total++;
                if (a_ph !== sb[i].ph || a_dir !== sb[i].dir || a_red !== sb[i].red ||
                    a_yel !== sb[i].yel || a_grn !== sb[i].grn || a_pend !== sb[i].pend) begin
                    bad++;
                    $display("FAIL %0s cyc=%0d got ph=%0d dir=%0d r=%b y=%b g=%b p=%b want ph=%0d dir=%0d r=%b y=%b g=%b p=%b",
                             sb[i].name, cyc, a_ph, a_dir, a_red, a_yel, a_grn, a_pend,
                             sb[i].ph, sb[i].dir, sb[i].red, sb[i].yel, sb[i].grn, sb[i].pend);
                end else begin
                    $display("ok   %0s cyc=%0d ph=%0d dir=%0d r=%b y=%b g=%b p=%b",
                             sb[i].name, cyc, a_ph, a_dir, a_red, a_yel, a_grn, a_pend);
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        res0 = 1'b1; en0 = 1'b1; req0 = 4'h0;
        res1 = 1'b1; en1 = 1'b1; req1 = 4'h0;

        // ---- strict rotation instance ----
        exp_allred(0, R, "rst0", 2'd3, 4'h0);
        for (int d = 0; d < 5; d++) begin
            exp_green (0, R + 1 + 13 * d,  "rot_g_first", 2'(d % 4), 4'h0);
            exp_green (0, R + 10 + 13 * d, "rot_g_last",  2'(d % 4), 4'h0);
            exp_yellow(0, R + 11 + 13 * d, "rot_yellow",  2'(d % 4), 4'h0);
            exp_allred(0, R + 13 + 13 * d, "rot_allred",  2'(d % 4), 4'h0);
        end
        exp_green (0, R + 66, "g_dir1",      2'd1, 4'h0);
        exp_green (0, R + 68, "g_dir1_late", 2'd1, 4'h0);
        exp_flash (0, R + 69, "flash_on0",   2'd1, 4'hF, 4'h0);
        exp_flash (0, R + 72, "flash_on3",   2'd1, 4'hF, 4'h0);
        exp_flash (0, R + 73, "flash_off0",  2'd1, 4'h0, 4'h0);
        exp_flash (0, R + 76, "flash_off3",  2'd1, 4'h0, 4'h0);
        exp_flash (0, R + 77, "flash_on_b",  2'd1, 4'hF, 4'h0);
        exp_allred(0, R + 79, "resume_ar",   2'd1, 4'h0);
        exp_green (0, R + 80, "resume_g2",   2'd2, 4'h0);
        exp_green (0, R + 86, "pend_latch",  2'd2, 4'h8);
        exp_yellow(0, R + 90, "mid_yellow",  2'd2, 4'h8);
        exp_allred(0, R + 91, "rst_mid",     2'd3, 4'h0);
        exp_green (0, R + 92, "rst_g0",      2'd0, 4'h0);
        exp_allred(0, R + 101, "rst_en0_a",  2'd3, 4'h0);
        exp_allred(0, R + 102, "rst_en0_b",  2'd3, 4'h0);
        exp_allred(0, R + 103, "rst_en0_c",  2'd3, 4'h0);
        exp_green (0, R + 104, "post_rst_g0", 2'd0, 4'h0);

        // ---- skip-empty instance ----
        exp_allred(1, R,      "rst1",        2'd3, 4'h0);
        exp_allred(1, R + 1,  "rest_idle",   2'd3, 4'h0);
        exp_allred(1, R + 5,  "req2_latch",  2'd3, 4'h4);
        exp_green (1, R + 6,  "skip_g2",     2'd2, 4'h0);
        exp_yellow(1, R + 16, "skip_y2",     2'd2, 4'h0);
        exp_allred(1, R + 18, "skip_ar2",    2'd2, 4'h0);
        exp_allred(1, R + 25, "rest_again",  2'd2, 4'h0);
        exp_allred(1, R + 31, "req3_latch",  2'd2, 4'h8);
        exp_green (1, R + 32, "skip_g3",     2'd3, 4'h0);
        exp_green (1, R + 34, "g3_pend1011", 2'd3, 4'hB);
        exp_yellow(1, R + 42, "y3_pend",     2'd3, 4'hB);
        exp_allred(1, R + 44, "ar3_pend",    2'd3, 4'hB);
        exp_green (1, R + 45, "order_g0",    2'd0, 4'hA);
        exp_green (1, R + 58, "order_g1",    2'd1, 4'h8);
        exp_green (1, R + 71, "order_g3",    2'd3, 4'h0);
        exp_allred(1, R + 84, "rest_end",    2'd3, 4'h0);
        exp_allred(1, R + 90, "rest_end_b",  2'd3, 4'h0);
        exp_green (1, R + 97, "setwins_g0",  2'd0, 4'h1);
        exp_green (1, R + 110, "reserve_g0", 2'd0, 4'h0);

        // ---- stimulus, in cycle order ----
        wait_cyc(R);      res0 = 1'b0; res1 = 1'b0;
        wait_cyc(R + 4);  req1 = 4'b0100;
        wait_cyc(R + 5);  req1 = 4'b0000;
        wait_cyc(R + 30); req1 = 4'b1000;
        wait_cyc(R + 31); req1 = 4'b0000;
        wait_cyc(R + 33); req1 = 4'b1011;
        wait_cyc(R + 34); req1 = 4'b0000;
        wait_cyc(R + 68); en0 = 1'b0;
        wait_cyc(R + 78); en0 = 1'b1;
        wait_cyc(R + 85); req0 = 4'b1000;
        wait_cyc(R + 86); req0 = 4'b0000;
        wait_cyc(R + 90); res0 = 1'b1;
        wait_cyc(R + 91); res0 = 1'b0;
        wait_cyc(R + 95); req1 = 4'b0001;
        wait_cyc(R + 97); req1 = 4'b0000;
        wait_cyc(R + 100); res0 = 1'b1; en0 = 1'b0;
        wait_cyc(R + 103); res0 = 1'b0; en0 = 1'b1;
        wait_cyc(R + 113);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
